// File: rtl/uart_rx_frame_ctrl_pkg.sv
// uart_rx_pkg: shared types, limits and helpers for the UART receive
// frame controller (state encoding, data-width limits, parity check,
// data-width clamp).
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } uart_rx_state_e;

    localparam int MIN_DATA_BITS      = 5;
    localparam int MAX_DATA_BITS      = 9;
    localparam int DEFAULT_OVERSAMPLE = 16;

    // Parity is bad when data XOR plus the parity bit does not give the
    // configured sense (1 for odd, 0 for even).
    function automatic logic parity_fail(input logic data_xor,
                                         input logic parity_bit,
                                         input logic odd);
        return ((data_xor ^ parity_bit) != odd);
    endfunction

    // Force a requested data width into the supported range.
    function automatic logic [3:0] clamp_data_bits(input logic [3:0] req,
                                                   input logic [3:0] max_bits);
        logic [3:0] res;
        if (req < 4'(MIN_DATA_BITS)) begin
            res = 4'(MIN_DATA_BITS);
        end else if (req > max_bits) begin
            res = max_bits;
        end else begin
            res = req;
        end
        return res;
    endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// uart_rx_frame_ctrl_if: controller-to-shift-register bundle.
//   sample_enable / bit_sample / bit_count : data-bit sample strobe, value, 1-based index
//   is_data_bit                            : high while data bits are being received
//   frame_complete                         : one-cycle end-of-frame pulse
//   busy                                   : frame in progress
//   parity_error / framing_error / break_detect : status, valid with frame_complete
// master = frame controller, slave = shift register / status consumer.
interface uart_rx_frame_ctrl_if;
    logic       sample_enable;
    logic       bit_sample;
    logic [3:0] bit_count;
    logic       is_data_bit;
    logic       frame_complete;
    logic       busy;
    logic       parity_error;
    logic       framing_error;
    logic       break_detect;

    modport master (
        output sample_enable, bit_sample, bit_count, is_data_bit,
               frame_complete, busy, parity_error, framing_error, break_detect
    );

    modport slave (
        input  sample_enable, bit_sample, bit_count, is_data_bit,
               frame_complete, busy, parity_error, framing_error, break_detect
    );
endinterface

// File: rtl/uart_rx_frame_ctrl_bit_timer.sv
// uart_rx_bit_timer: oversample tick counter for the UART receiver.
//   clk, rst  : clock, asynchronous active-high reset
//   tick      : oversample tick; counter advances only on ticks
//   clear     : synchronous clear (wins over tick)
//   mid_start : tick that lands half a bit after the counter was cleared
//   mid_bit   : tick that completes a full bit period (counter wraps)
module uart_rx_bit_timer #(
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic clear,
    output logic mid_start,
    output logic mid_bit
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);

    logic [CW-1:0] cnt_r;

    // Tick counter; wraps naturally modulo OVERSAMPLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (tick) begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    assign mid_start = tick && (cnt_r == HALF_LAST);
    assign mid_bit   = tick && (cnt_r == FULL_LAST);

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: frame-sequencing FSM for the UART receive path.
//   clk, rst        : clock, asynchronous active-high reset
//   baud_tick       : oversample tick (OVERSAMPLE per bit)
//   rx_sync         : synchronized RX line, idle high
//   rx_enable       : permits detection of a new frame
//   data_bits, parity_en, parity_odd, two_stop : frame format, latched at start
//   bus (master)    : sample strobe / index / status outputs, all registered
module uart_rx_frame_ctrl #(
    parameter int OVERSAMPLE    = uart_rx_pkg::DEFAULT_OVERSAMPLE,
    parameter int MAX_DATA_BITS = uart_rx_pkg::MAX_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx_sync,
    input  logic                 rx_enable,
    input  logic [3:0]           data_bits,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 two_stop,
    uart_rx_frame_ctrl_if.master bus
);
    import uart_rx_pkg::*;

    uart_rx_state_e state_r, next_state_s;

    logic       timer_clear_s, mid_start_s, mid_bit_s;
    logic [3:0] cfg_bits_r;
    logic       cfg_par_en_r, cfg_par_odd_r, cfg_two_stop_r;
    logic       xor_r, all_zero_r, par_bit_r, par_fail_r, frame_fail_r;
    logic       stop0_r, stop_second_r;

    logic       sample_enable_r, bit_sample_r, is_data_bit_r, frame_complete_r;
    logic       busy_r, parity_error_r, framing_error_r, break_detect_r;
    logic [3:0] bit_count_r;

    uart_rx_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .tick      (baud_tick),
        .clear     (timer_clear_s),
        .mid_start (mid_start_s),
        .mid_bit   (mid_bit_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic and tick-counter clear.
    always_comb begin
        next_state_s  = state_r;
        timer_clear_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                timer_clear_s = 1'b1;
                if (baud_tick && rx_enable && !rx_sync) begin
                    next_state_s = ST_START;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (mid_start_s) begin
                    // Counter restarts at mid start bit so every later
                    // wrap lands in the middle of a bit.
                    timer_clear_s = 1'b1;
                    next_state_s  = rx_sync ? ST_IDLE : ST_DATA;
                end else begin
                    next_state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (mid_bit_s && ((bit_count_r + 4'd1) == cfg_bits_r)) begin
                    next_state_s = cfg_par_en_r ? ST_PARITY : ST_STOP;
                end else begin
                    next_state_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (mid_bit_s) begin
                    next_state_s = ST_STOP;
                end else begin
                    next_state_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (mid_bit_s && (!cfg_two_stop_r || stop_second_r)) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_STOP;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Frame datapath: config latch, sampling, parity/stop checks and
    // registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_bits_r       <= 4'd0;
            cfg_par_en_r     <= 1'b0;
            cfg_par_odd_r    <= 1'b0;
            cfg_two_stop_r   <= 1'b0;
            xor_r            <= 1'b0;
            all_zero_r       <= 1'b0;
            par_bit_r        <= 1'b0;
            par_fail_r       <= 1'b0;
            frame_fail_r     <= 1'b0;
            stop0_r          <= 1'b0;
            stop_second_r    <= 1'b0;
            sample_enable_r  <= 1'b0;
            bit_sample_r     <= 1'b0;
            bit_count_r      <= 4'd0;
            is_data_bit_r    <= 1'b0;
            frame_complete_r <= 1'b0;
            busy_r           <= 1'b0;
            parity_error_r   <= 1'b0;
            framing_error_r  <= 1'b0;
            break_detect_r   <= 1'b0;
        end else begin
            sample_enable_r  <= 1'b0;
            frame_complete_r <= 1'b0;
            busy_r           <= (next_state_s != ST_IDLE);
            is_data_bit_r    <= (next_state_s == ST_DATA);
            case (state_r)
                ST_IDLE: begin
                    if (next_state_s == ST_START) begin
                        cfg_bits_r     <= clamp_data_bits(data_bits, 4'(MAX_DATA_BITS));
                        cfg_par_en_r   <= parity_en;
                        cfg_par_odd_r  <= parity_odd;
                        cfg_two_stop_r <= two_stop;
                        xor_r          <= 1'b0;
                        all_zero_r     <= 1'b1;
                        par_bit_r      <= 1'b0;
                        par_fail_r     <= 1'b0;
                        frame_fail_r   <= 1'b0;
                        stop0_r        <= 1'b1;
                        stop_second_r  <= 1'b0;
                    end
                end
                ST_START: begin
                end
                ST_DATA: begin
                    if (mid_bit_s) begin
                        sample_enable_r <= 1'b1;
                        bit_sample_r    <= rx_sync;
                        bit_count_r     <= bit_count_r + 4'd1;
                        xor_r           <= xor_r ^ rx_sync;
                        if (rx_sync) begin
                            all_zero_r <= 1'b0;
                        end
                    end
                end
                ST_PARITY: begin
                    if (mid_bit_s) begin
                        par_bit_r  <= rx_sync;
                        par_fail_r <= parity_fail(xor_r, rx_sync, cfg_par_odd_r);
                    end
                end
                ST_STOP: begin
                    if (mid_bit_s) begin
                        stop_second_r <= 1'b1;
                        if (!stop_second_r) begin
                            stop0_r <= rx_sync;
                        end
                        if (!rx_sync) begin
                            frame_fail_r <= 1'b1;
                        end
                        if (next_state_s == ST_DONE) begin
                            // Present status in the DONE cycle; the current
                            // stop sample is folded in directly.
                            frame_complete_r <= 1'b1;
                            parity_error_r   <= par_fail_r;
                            framing_error_r  <= frame_fail_r | ~rx_sync;
                            break_detect_r   <= all_zero_r
                                                && (!cfg_par_en_r || !par_bit_r)
                                                && (stop_second_r ? !stop0_r : !rx_sync);
                        end
                    end
                end
                ST_DONE: begin
                    bit_count_r     <= 4'd0;
                    bit_sample_r    <= 1'b0;
                    parity_error_r  <= 1'b0;
                    framing_error_r <= 1'b0;
                    break_detect_r  <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.sample_enable  = sample_enable_r;
    assign bus.bit_sample     = bit_sample_r;
    assign bus.bit_count      = bit_count_r;
    assign bus.is_data_bit    = is_data_bit_r;
    assign bus.frame_complete = frame_complete_r;
    assign bus.busy           = busy_r;
    assign bus.parity_error   = parity_error_r;
    assign bus.framing_error  = framing_error_r;
    assign bus.break_detect   = break_detect_r;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl (OVERSAMPLE=16, baud_tick tied high).
module tb_uart_rx_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_tick;
    logic       rx_sync;
    logic       rx_enable;
    logic [3:0] data_bits;
    logic       parity_en;
    logic       parity_odd;
    logic       two_stop;

    uart_rx_frame_ctrl_if bus();

    uart_rx_frame_ctrl #(.OVERSAMPLE(16), .MAX_DATA_BITS(9)) dut (
        .clk        (clk),
        .rst        (rst),
        .baud_tick  (baud_tick),
        .rx_sync    (rx_sync),
        .rx_enable  (rx_enable),
        .data_bits  (data_bits),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .two_stop   (two_stop),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: record sample strobes and frame completions away from posedge.
    logic       samp_val[$];
    logic [3:0] samp_idx[$];
    int         samp_cyc[$];
    int         fc_count;
    int         fc_cyc;
    logic [2:0] fc_flags;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.sample_enable) begin
                samp_val.push_back(bus.bit_sample);
                samp_idx.push_back(bus.bit_count);
                samp_cyc.push_back(cyc);
            end
            if (bus.frame_complete) begin
                fc_count = fc_count + 1;
                fc_cyc   = cyc;
                fc_flags = {bus.parity_error, bus.framing_error, bus.break_detect};
            end
        end
    end

    task automatic clear_mon();
        samp_val.delete();
        samp_idx.delete();
        samp_cyc.delete();
        fc_count = 0;
        fc_cyc   = 0;
        fc_flags = 3'b000;
    endtask

    function automatic logic [11:0] all_outs();
        return {bus.sample_enable, bus.bit_sample, bus.bit_count, bus.is_data_bit,
                bus.frame_complete, bus.busy, bus.parity_error, bus.framing_error,
                bus.break_detect};
    endfunction

    // Drive one complete frame on rx_sync, 16 clocks per bit, then idle.
    task automatic send_frame(input logic [8:0] data, input int nd, input bit pen,
                              input bit podd, input bit pbit, input bit two,
                              input bit s0, input bit s1, output int start_edge);
        data_bits  = 4'(nd);
        parity_en  = pen;
        parity_odd = podd;
        two_stop   = two;
        clear_mon();
        @(negedge clk);
        start_edge = cyc + 1;
        rx_sync = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < nd; i++) begin
            rx_sync = data[i];
            repeat (16) @(negedge clk);
        end
        if (pen) begin
            rx_sync = pbit;
            repeat (16) @(negedge clk);
        end
        rx_sync = s0;
        repeat (16) @(negedge clk);
        if (two) begin
            rx_sync = s1;
            repeat (16) @(negedge clk);
        end
        rx_sync = 1'b1;
        repeat (40) @(negedge clk);
    endtask

    // Compare recorded samples and completion against the frame sent.
    task automatic check_frame(input string tag, input logic [8:0] data, input int nd,
                               input int start_edge, input int fc_off, input logic [2:0] flags);
        check_eq({tag, " n_samples"}, samp_val.size(), nd);
        for (int i = 0; i < nd; i++) begin
            if (i < samp_val.size()) begin
                check_eq($sformatf("%s bit%0d value", tag, i), samp_val[i], data[i]);
                check_eq($sformatf("%s bit%0d count", tag, i), samp_idx[i], i + 1);
                check_eq($sformatf("%s bit%0d time", tag, i), samp_cyc[i] - start_edge, 24 + 16 * i);
            end
        end
        check_eq({tag, " fc_count"}, fc_count, 1);
        check_eq({tag, " fc_time"}, fc_cyc - start_edge, fc_off);
        check_eq({tag, " flags pe/fe/bd"}, fc_flags, flags);
        check_eq({tag, " busy_after"}, bus.busy, 1'b0);
        check_eq({tag, " bit_count_after"}, bus.bit_count, 4'd0);
    endtask

    int st;

    initial begin
        rst        = 1'b1;
        baud_tick  = 1'b1;
        rx_sync    = 1'b1;
        rx_enable  = 1'b1;
        data_bits  = 4'd8;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        two_stop   = 1'b0;
        clear_mon();
        repeat (3) @(negedge clk);
        check_eq("reset outputs", all_outs(), 12'h000);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 8N1 0xA5
        send_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, st);
        check_frame("8N1_A5", 9'h0A5, 8, st, 152, 3'b000);

        // False start: low for 4 ticks only
        clear_mon();
        @(negedge clk);
        rx_sync = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("false_start busy_during", bus.busy, 1'b1);
        rx_sync = 1'b1;
        repeat (30) @(negedge clk);
        check_eq("false_start n_samples", samp_val.size(), 0);
        check_eq("false_start fc_count", fc_count, 0);
        check_eq("false_start busy_after", bus.busy, 1'b0);

        // 7E1 0x35, correct then wrong parity bit
        send_frame(9'h035, 7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, st);
        check_frame("7E1_p0", 9'h035, 7, st, 24 + 96 + 32, 3'b000);
        send_frame(9'h035, 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, st);
        check_frame("7E1_p1", 9'h035, 7, st, 24 + 96 + 32, 3'b100);

        // Break and plain framing error
        send_frame(9'h000, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, st);
        check_frame("break_00", 9'h000, 8, st, 152, 3'b011);
        send_frame(9'h001, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, st);
        check_frame("frame_01", 9'h001, 8, st, 152, 3'b010);

        // Reset in the middle of data bit 4
        data_bits = 4'd8;
        parity_en = 1'b0;
        two_stop  = 1'b0;
        clear_mon();
        @(negedge clk);
        rx_sync = 1'b0;
        repeat (16) @(negedge clk);
        rx_sync = 1'b1;
        repeat (48) @(negedge clk);
        repeat (4) @(negedge clk);
        check_eq("abort n_samples_before", samp_val.size(), 3);
        check_eq("abort is_data_bit_before", bus.is_data_bit, 1'b1);
        rst = 1'b1;
        #1;
        check_eq("abort outputs_in_reset", all_outs(), 12'h000);
        rx_sync = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        check_eq("abort fc_count", fc_count, 0);
        check_eq("abort n_samples_after", samp_val.size(), 3);

        send_frame(9'h03C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, st);
        check_frame("8N1_3C", 9'h03C, 8, st, 152, 3'b000);

        // 9 bits, two stop bits, data_bits changed mid-frame
        fork
            send_frame(9'h1A5, 9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, st);
            begin
                repeat (60) @(negedge clk);
                data_bits = 4'd5;
            end
        join
        check_frame("9N2_1A5", 9'h1A5, 9, st, 24 + 128 + 32, 3'b000);
        if (samp_cyc.size() == 9) begin
            check_eq("9N2 fc_after_last_sample", fc_cyc - samp_cyc[8], 32);
        end else begin
            check_eq("9N2 sample_queue_size", samp_cyc.size(), 9);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
